test_mode_ctrl: RTL and testbench

TEST_MODE_CTRL -- requirements
Module: test_mode_ctrl

---
 rtl/test_mode_pkg.sv | 24 ++
 rtl/test_mode_ctrl_edge_rise.sv | 18 +
 rtl/test_mode_ctrl.sv | 120 ++++++++++++
 tb/tb_test_mode_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/test_mode_pkg.sv
// Shared types and helpers for the pet test-mode controller.
// Optional idle auto-exit is compiled in with the TEST_TIMEOUT_EN macro.
package test_mode_pkg;

    localparam int TSTATE_W = 4;
    localparam int IDLE_W   = 8;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ENTER  = 2'd1,
        TEST   = 2'd2,
        EXIT   = 2'd3
    } tm_state_t;

    function automatic logic [TSTATE_W-1:0] wrap_inc(input logic [TSTATE_W-1:0] v,
                                                     input int unsigned n);
        return (32'(v) >= n - 1) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/test_mode_ctrl_edge_rise.sv
// Rising-edge detector: one history register, pulse when the input goes 0 -> 1.
module edge_rise (
    input  logic clkmseg,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clkmseg or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/test_mode_ctrl.sv
// Test-mode sequencer: forces pet states on btn_next presses while test mode is active.
// Define TEST_TIMEOUT_EN to build the idle auto-exit counter.
//
// state  | meaning
// NORMAL | test mode off, btn_next ignored
// ENTER  | one cycle: test_state loaded with 0, strobe pulsed
// TEST   | btn_next edges step test_state, btn_test leaves
// EXIT   | one cycle: test_active low, test_state cleared on the way out
module test_mode_ctrl
    import test_mode_pkg::*;
#(
    parameter int NUM_STATES   = 6,
    parameter int IDLE_TIMEOUT = 20
) (
    input  logic                clkmseg,
    input  logic                rst,
    input  logic                btn_test,
    input  logic                btn_next,
    output logic                test_active,
    output logic [TSTATE_W-1:0] test_state,
    output logic                state_strobe
);

    if (NUM_STATES < 2 || NUM_STATES > 16) begin : g_bad_num_states
        $error("test_mode_ctrl: NUM_STATES out of range 2..16");
    end
    if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_bad_idle_timeout
        $error("test_mode_ctrl: IDLE_TIMEOUT out of range 1..255");
    end

    tm_state_t           state, state_nxt;
    logic [TSTATE_W-1:0] tstate_nxt;
    logic                strobe_nxt;
    logic                active_nxt;
    logic                next_rise;

    edge_rise u_next_edge (
        .clkmseg (clkmseg),
        .rst     (rst),
        .din     (btn_next),
        .rise    (next_rise)
    );

`ifdef TEST_TIMEOUT_EN
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic              idle_expired;

    // Leaving on the cycle the count would reach IDLE_TIMEOUT gives exactly IDLE_TIMEOUT TEST cycles.
    assign idle_expired = (idle_cnt >= IDLE_LAST);
`endif

    always_comb begin
        state_nxt  = state;
        tstate_nxt = test_state;
        strobe_nxt = 1'b0;
`ifdef TEST_TIMEOUT_EN
        idle_nxt   = '0;
`endif
        case (state)
            NORMAL: begin
                if (btn_test) begin
                    state_nxt  = ENTER;
                    tstate_nxt = '0;
                    strobe_nxt = 1'b1;
                end
            end
            ENTER: begin
                state_nxt = TEST;
            end
            TEST: begin
`ifdef TEST_TIMEOUT_EN
                idle_nxt = sat_inc(idle_cnt);
`endif
                // btn_test has priority over a coincident btn_next edge.
                if (btn_test) begin
                    state_nxt = EXIT;
                end else if (next_rise) begin
                    tstate_nxt = wrap_inc(test_state, NUM_STATES);
                    strobe_nxt = 1'b1;
`ifdef TEST_TIMEOUT_EN
                    idle_nxt   = '0;
                end else if (idle_expired) begin
                    state_nxt  = EXIT;
`endif
                end
            end
            EXIT: begin
                state_nxt  = NORMAL;
                tstate_nxt = '0;
            end
            default: begin
                state_nxt = NORMAL;
            end
        endcase
        active_nxt = (state_nxt == ENTER) || (state_nxt == TEST);
    end

    always_ff @(posedge clkmseg or posedge rst) begin
        if (rst) begin
            state        <= NORMAL;
            test_active  <= 1'b0;
            test_state   <= '0;
            state_strobe <= 1'b0;
`ifdef TEST_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            test_active  <= active_nxt;
            test_state   <= tstate_nxt;
            state_strobe <= strobe_nxt;
`ifdef TEST_TIMEOUT_EN
            idle_cnt     <= idle_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_test_mode_ctrl.sv
// Self-checking bench for test_mode_ctrl: vector table plus reset and idle-timeout sequences.
module tb_test_mode_ctrl;
    import test_mode_pkg::*;

    logic       clkmseg = 1'b0;
    logic       rst;
    logic       btn_test;
    logic       btn_next;
    logic       test_active;
    logic [3:0] test_state;
    logic       state_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       t;
        logic       n;
        logic       a;
        logic [3:0] s;
        logic       b;
        string      name;
    } vec_t;

    vec_t vecs[$];

    test_mode_ctrl #(.NUM_STATES(6), .IDLE_TIMEOUT(20)) dut (
        .clkmseg      (clkmseg),
        .rst          (rst),
        .btn_test     (btn_test),
        .btn_next     (btn_next),
        .test_active  (test_active),
        .test_state   (test_state),
        .state_strobe (state_strobe)
    );

    always #5 clkmseg = ~clkmseg;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic a, input logic [3:0] s, input logic b);
        chk({name, ".active"}, 8'(test_active), 8'(a));
        chk({name, ".state"},  8'(test_state),  8'(s));
        chk({name, ".strobe"}, 8'(state_strobe), 8'(b));
    endtask

    task automatic tick();
        @(posedge clkmseg);
        #1;
    endtask

    function automatic void add(input logic t, input logic n, input logic a,
                                input logic [3:0] s, input logic b, input string name);
        vec_t v;
        v.t = t; v.n = n; v.a = a; v.s = s; v.b = b; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; btn_test = 1'b0; btn_next = 1'b0;

        // Vector table: {btn_test, btn_next} -> {test_active, test_state, state_strobe} after one edge.
        add(0, 1, 0, 0, 0, "normal_next_ignored");
        add(0, 0, 0, 0, 0, "normal_idle");
        add(1, 0, 1, 0, 1, "enter");
        add(0, 0, 1, 0, 0, "test_first");
        for (int i = 0; i < 7; i++) begin
            add(0, 1, 1, 4'((i + 1) % 6), 1, $sformatf("press%0d", i));
            add(0, 0, 1, 4'((i + 1) % 6), 0, $sformatf("release%0d", i));
        end
        add(0, 1, 1, 2, 1, "hold_first");
        for (int i = 0; i < 9; i++) add(0, 1, 1, 2, 0, $sformatf("hold%0d", i));
        add(0, 0, 1, 2, 0, "hold_release");
        add(1, 1, 0, 2, 0, "test_wins_over_next");
        add(1, 0, 0, 0, 0, "exit_ignores_test");
        add(0, 0, 0, 0, 0, "normal_after_exit");
        add(1, 0, 1, 0, 1, "reenter");
        add(1, 0, 1, 0, 0, "enter_ignores_test");
        add(0, 0, 1, 0, 0, "test_hold");
        add(1, 0, 0, 0, 0, "exit_plain");
        add(0, 0, 0, 0, 0, "normal_again");

        #12;
        chk_out("reset", 0, 0, 0);
        chk("reset.fsm", 8'(dut.state), 8'(NORMAL));
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_test = vecs[i].t;
            btn_next = vecs[i].n;
            tick();
            chk_out(vecs[i].name, vecs[i].a, vecs[i].s, vecs[i].b);
        end
        btn_test = 1'b0; btn_next = 1'b0;

        // Idle behaviour with no presses.
        btn_test = 1'b1;
        tick();
        chk_out("to_enter", 1, 0, 1);
        btn_test = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("idle_active%0d", i), 8'(test_active), 8'd1);
        end
`ifdef TEST_TIMEOUT_EN
        tick();
        chk_out("timeout_exit", 0, 0, 0);
        chk("timeout_exit.fsm", 8'(dut.state), 8'(EXIT));
        tick();
        chk("timeout_normal.fsm", 8'(dut.state), 8'(NORMAL));
`else
        for (int i = 21; i <= 100; i++) begin
            tick();
            chk($sformatf("idle_active%0d", i), 8'(test_active), 8'd1);
        end
        chk("no_timeout.fsm", 8'(dut.state), 8'(TEST));
        btn_test = 1'b1;
        tick();
        chk_out("manual_exit", 0, 0, 0);
        btn_test = 1'b0;
        tick();
        chk("manual_normal.fsm", 8'(dut.state), 8'(NORMAL));
`endif

        // Asynchronous reset mid-TEST with test_state = 3.
        btn_test = 1'b1;
        tick();
        btn_test = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
            tick();
        end
        chk_out("pre_reset", 1, 3, 0);
        #2 rst = 1'b1;
        #1;
        chk_out("async_reset", 0, 0, 0);
        chk("async_reset.fsm", 8'(dut.state), 8'(NORMAL));
        #2 rst = 1'b0;
        tick();
        chk_out("post_reset", 0, 0, 0);
        chk("post_reset.fsm", 8'(dut.state), 8'(NORMAL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
